// File: rtl/alu_operand_fetch.sv
// Operand fetch for the 3-bit ALU: register file, busy-bit scoreboard, registered valid/ready output.
// Latency: 1 cycle from accept to out_valid. Backpressure: out_ready low holds out_* and drops in_ready.
// Optional: ALU_OPFETCH_BYPASS_EN forwards same-cycle writeback data into operands and hazard checks.
module alu_operand_fetch #(
    parameter int DATA_W   = 32,
    parameter int NUM_REGS = 32,
    parameter int AW       = $clog2(NUM_REGS)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        in_alu_op,
    input  logic [AW-1:0]     in_rs1,
    input  logic [AW-1:0]     in_rs2,
    input  logic [AW-1:0]     in_rd,
    input  logic              in_rd_en,
    input  logic              in_use_imm,
    input  logic [DATA_W-1:0] in_imm,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [2:0]        out_alu_op,
    output logic [DATA_W-1:0] out_operand1,
    output logic [DATA_W-1:0] out_operand2,
    output logic [AW-1:0]     out_rd,
    output logic              out_rd_en,
    input  logic              wb_en,
    input  logic [AW-1:0]     wb_rd,
    input  logic [DATA_W-1:0] wb_data,
    input  logic              flush
);

`ifdef ALU_OPFETCH_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    logic [DATA_W-1:0] regs [NUM_REGS];
    logic [NUM_REGS-1:0] busy;

    logic              wb_hit;
    logic              fwd1, fwd2, fwdd;
    logic              haz1, haz2, hazd, hazard;
    logic              accept;
    logic [DATA_W-1:0] val1, val2;

    assign wb_hit = wb_en && (wb_rd != '0);

    always_comb begin
        fwd1 = BYPASS && wb_hit && (wb_rd == in_rs1);
        fwd2 = BYPASS && wb_hit && (wb_rd == in_rs2);
        fwdd = BYPASS && wb_hit && (wb_rd == in_rd);

        haz1   = (in_rs1 != '0) && busy[in_rs1] && !fwd1;
        haz2   = !in_use_imm && (in_rs2 != '0) && busy[in_rs2] && !fwd2;
        hazd   = in_rd_en && (in_rd != '0) && busy[in_rd] && !fwdd;
        hazard = haz1 || haz2 || hazd;

        // x0 is hardwired; forwarded data only ever comes from a nonzero wb_rd
        val1 = (in_rs1 == '0) ? '0 : (fwd1 ? wb_data : regs[in_rs1]);
        val2 = (in_rs2 == '0) ? '0 : (fwd2 ? wb_data : regs[in_rs2]);
        if (in_use_imm) begin
            val2 = in_imm;
        end
    end

    assign in_ready = !flush && !hazard && (!out_valid || out_ready);
    assign accept   = in_valid && in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid    <= 1'b0;
            out_alu_op   <= '0;
            out_operand1 <= '0;
            out_operand2 <= '0;
            out_rd       <= '0;
            out_rd_en    <= 1'b0;
        end else begin
            if (flush) begin
                out_valid <= 1'b0;
            end else if (accept) begin
                out_valid <= 1'b1;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
            if (accept) begin
                out_alu_op   <= in_alu_op;
                out_operand1 <= val1;
                out_operand2 <= val2;
                out_rd       <= in_rd;
                out_rd_en    <= in_rd_en;
            end
        end
    end

    // Scoreboard: flush clears everything; a same-cycle issue beats a writeback clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy <= '0;
        end else begin
            for (int i = 1; i < NUM_REGS; i++) begin
                if (flush) begin
                    busy[i] <= 1'b0;
                end else if (accept && in_rd_en && (in_rd == AW'(i))) begin
                    busy[i] <= 1'b1;
                end else if (wb_hit && (wb_rd == AW'(i))) begin
                    busy[i] <= 1'b0;
                end
            end
            busy[0] <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else if (wb_hit) begin
            regs[wb_rd] <= wb_data;
        end
    end

endmodule

// File: doc/alu_operand_fetch.md
# alu_operand_fetch

Operand-fetch stage directly upstream of the 3-bit-opcode ALU. Holds the architectural register file, reads two source registers per instruction and selects an immediate for operand2. A busy-bit scoreboard stalls instructions that depend on results not yet written back. It presents alu_op / operand1 / operand2 to the ALU from a registered valid/ready output stage.

## Interface
- DATA_W, 32, register and operand width
- NUM_REGS, 32, register count; AW = $clog2(NUM_REGS) is the address width
- clk  in  1  clock, all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  upstream instruction valid
- in_ready  out  1  stage accepts the instruction this cycle
- in_alu_op  in  3  ALU opcode, passed through unchanged
- in_rs1, in_rs2  in  AW  source register indices
- in_rd  in  AW  destination index
- in_rd_en  in  1  instruction writes rd
- in_use_imm  in  1  operand2 = in_imm; rs2 ignored for the hazard check
- in_imm  in  DATA_W  immediate
- out_valid  out  1  ALU inputs valid
- out_ready  in  1  downstream consumes this cycle
- out_alu_op  out  3; out_operand1, out_operand2  out  DATA_W; out_rd  out  AW; out_rd_en  out  1
- wb_en  in  1  writeback strobe
- wb_rd  in  AW  writeback index
- wb_data  in  DATA_W  writeback data
- flush  in  1  discard in-flight output, clear scoreboard

## Operation
- Register 0 always reads 0. Writes to register 0 are ignored, and it is never marked busy.
- Source hazard:
  - rs1 != 0 and busy[rs1], or
  - !in_use_imm and rs2 != 0 and busy[rs2].
- WAW hazard: in_rd_en and rd != 0 and busy[rd].
- in_ready = !flush && !hazard && (!out_valid || out_ready).
  - in_ready may depend combinationally on the in_* fields.
  - Upstream holds in_valid and its fields stable until accepted.
- Accept (in_valid && in_ready):
  - Output register loads opcode, operands, rd, rd_en.
  - out_valid <= 1.
  - busy[rd] <= 1 if rd_en and rd != 0.
- Output drain: out_valid && out_ready with no accept -> out_valid <= 0.
- Output stall: out_valid && !out_ready -> all out_* held stable.
- Writeback (wb_en && wb_rd != 0):
  - regs[wb_rd] <= wb_data.
  - busy[wb_rd] <= 0, unless the same cycle's accept sets it, in which case set wins.
  - A writeback to a non-busy register is legal and simply writes.
- Flush:
  - out_valid <= 0.
  - All busy bits <= 0.
  - in_ready = 0.
  - A writeback in the same cycle still updates the register.
- Operand formation:
  - operand1 = value(rs1).
  - operand2 = in_use_imm ? in_imm : value(rs2).
  - value() follows the read rules under Configuration.

## Timing
- Reset (async assert, sync-safe deassert):
  - all registers 0, all busy 0;
  - out_valid 0, out_alu_op 0, out_operand1/2 0, out_rd 0, out_rd_en 0.
- Latency: accept at edge N -> out_valid high after edge N.
- Throughput: one instruction per cycle when there is no hazard and out_ready = 1.
- Writeback at edge N clears busy and updates the register at edge N.
- Reset mid-operation: all in-flight output and scoreboard state is lost; no writeback is retained.

## Configuration
- ALU_OPFETCH_BYPASS_EN defined:
  - A wb_en write to a busy source register in the same cycle resolves that source's hazard. The operand takes wb_data.
  - A same-cycle writeback to a busy rd resolves WAW.
  - Back-to-back dependent issue is possible in the writeback cycle.
- Undefined:
  - No forwarding; reads return register contents from before the edge.
  - A dependent instruction stalls until the cycle after its writeback, adding one cycle versus the bypass build.

## Test plan
- Reset:
  - Stimulus: rst_n low mid-stream, then released.
  - Required: out_valid 0 and all out_* 0. Reading x1..x31 yields 0.
- Independent issue:
  - Stimulus: write x1=5 and x2=7 via wb, then issue op 000 rs1=1 rs2=2.
  - Required: out_operand1=5, out_operand2=7, out_alu_op=000, one cycle after accept.
- Immediate and x0:
  - Stimulus: issue rs1=0, use_imm=1, imm=0xFFFF_FFF0.
  - Required: operand1=0, operand2=0xFFFF_FFF0.
  - Stimulus: wb to x0.
  - Required: x0 still reads 0.
- RAW stall:
  - Stimulus: issue rd=3, then rs1=3.
  - Required: second instruction sees in_ready=0 until wb x3=0x1234.
  - With the macro, it issues in the wb cycle with operand1=0x1234.
  - Without the macro, it issues one cycle later with the same value.
- Backpressure:
  - Stimulus: out_ready=0 for 3 cycles with a valid output.
  - Required: out_* stable and in_ready=0.
  - Stimulus: out_ready returns to 1.
  - Required: the next queued instruction is accepted that same cycle.
- Flush:
  - Stimulus: issue rd=4, then assert flush.
  - Required: out_valid=0 and busy[4] cleared. A following rs1=4 instruction issues without stalling.
